controle_multiciclo: RTL and testbench

- Multicycle control unit sitting directly upstream of the load/store datapath (adder, 32x64 register file, data memory, Mux1 and Mux2).
- Fetches 32-bit RV64 subset instructions from an external combinational instruction ROM and decodes them.
- Sequences a FETCH/DECODE/EXEC/MEM/WB FSM and drives every datapath control signal. These signals were previously hand-driven by the bench.

---
 rtl/controle_multiciclo.sv | 123 ++++++++++++
 tb/tb_controle_multiciclo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle RV64 control (ld/sd/add/sub/addi/ecall): FETCH-DECODE-EXEC-MEM-WB, 4-5 cycles per instr, ecall halts after 2.
// run=0 stalls every register and masks both write enables; the pending write fires when run returns.
module controle_multiciclo #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] instr_addr,
  input  logic [31:0]     instr_data,
  output logic [4:0]      Ra,
  output logic [4:0]      Rb,
  output logic [4:0]      Rw,
  output logic [63:0]     C,
  output logic            sinal,
  output logic            sinalMux,
  output logic            weReg,
  output logic            weMem,
  output logic            halt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic            illegal_q;
  logic            mux_hold;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_ld;
  logic       is_sd;
  logic       is_add;
  logic       is_sub;
  logic       is_addi;
  logic       is_ecall;
  logic       is_legal;
  logic       mux_now;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign is_ld    = (opcode == 7'b0000011) && (funct3 == 3'b011);
  assign is_sd    = (opcode == 7'b0100011) && (funct3 == 3'b011);
  assign is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_ecall = (ir == 32'h0000_0073);
  assign is_legal = is_ld | is_sd | is_add | is_sub | is_addi | is_ecall;

  // Fields decode straight from IR, which only changes at the end of FETCH,
  // so they are naturally held through FETCH of the next instruction.
  assign Ra = ir[19:15];
  assign Rb = ir[24:20];
  assign Rw = ir[11:7];

  always_comb begin
    C = '0;
    if (is_ld || is_addi) begin
      C = {{52{ir[31]}}, ir[31:20]};
    end else if (is_sd) begin
      C = {{52{ir[31]}}, ir[31:25], ir[11:7]};
    end
  end

  assign sinal = is_sub;

  // addi raises the select only in WB, so the FETCH value comes from a hold register.
  assign mux_now  = is_add | is_sub | (is_addi && (state == S_WB));
  assign sinalMux = (state == S_FETCH) ? mux_hold : mux_now;

  assign weReg      = run && (state == S_WB) && (Rw != 5'd0);
  assign weMem      = run && (state == S_MEM) && is_sd;
  assign halt       = (state == S_HALT);
  assign illegal    = illegal_q;
  assign instr_addr = pc;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = (is_ecall || !is_legal) ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = (is_ld || is_sd) ? S_MEM : S_WB;
      S_MEM:    state_nxt = is_sd ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      illegal_q <= 1'b0;
      mux_hold  <= 1'b0;
    end else if (run) begin
      state    <= state_nxt;
      mux_hold <= sinalMux;
      if (state == S_FETCH) begin
        ir <= instr_data;
        pc <= pc + PC_W'(4);
      end
      if ((state == S_DECODE) && !is_legal) begin
        illegal_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: a program-level model predicts every write pulse and halt;
// a negedge monitor pops and compares each weReg/weMem pulse against it.
module tb_controle_multiciclo;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
  logic [PC_W-1:0] instr_addr;
  logic [31:0]     instr_data;
  logic [4:0]      Ra, Rb, Rw;
  logic [63:0]     C;
  logic            sinal, sinalMux, weReg, weMem, halt, illegal;

  logic [31:0] rom [64];
  assign instr_data = rom[instr_addr[7:2]];

  always #5 clk = ~clk;

  controle_multiciclo #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .C(C),
    .sinal(sinal), .sinalMux(sinalMux),
    .weReg(weReg), .weMem(weMem),
    .halt(halt), .illegal(illegal)
  );

  typedef struct {
    bit        mem;
    bit [4:0]  ra, rb, rw;
    bit [63:0] c;
    bit        sinal, smux;
    int        act;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  act_cnt = 0;
  int  halt_act = 0;
  bit  halt_seen = 1'b0;
  bit  exp_halt, exp_ill;
  int  halt_at, t_end, end_pc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [63:0] sx12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

  // Monitor: counts cycles in which run=1 and checks every write pulse.
  always @(negedge clk) begin
    int  prev;
    ev_t e;
    if (!rst_n) begin
      act_cnt   = 0;
      halt_seen = 1'b0;
    end else begin
      prev = act_cnt;
      if (run) act_cnt++;
      if (halt && !halt_seen) begin
        halt_seen = 1'b1;
        halt_act  = prev;
      end
      if (weReg || weMem) begin
        chk("we_onehot", weReg & weMem, 0);
        chk("we_while_run", run, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("we_kind_mem", weMem, e.mem);
          chk("ev_Ra", Ra, e.ra);
          chk("ev_Rb", Rb, e.rb);
          chk("ev_Rw", Rw, e.rw);
          chk("ev_C", C, e.c);
          chk("ev_sinal", sinal, e.sinal);
          chk("ev_sinalMux", sinalMux, e.smux);
          chk("ev_cycle", act_cnt, e.act);
        end
      end
    end
  end

  // Program-level model: walk the ROM, accumulate per-instruction latencies.
  task automatic build_model(input int max_instr);
    int          pc, t;
    logic [31:0] w;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    ev_t         e;
    exp_q.delete();
    pc = 0; t = 0; exp_halt = 0; exp_ill = 0; halt_at = 0;
    for (int n = 0; n < max_instr; n++) begin
      w = rom[pc / 4];
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      e.mem = 0; e.ra = w[19:15]; e.rb = w[24:20]; e.rw = w[11:7];
      e.c = 0; e.sinal = 0; e.smux = 0;
      if (w == 32'h0000_0073) begin
        exp_halt = 1; halt_at = t + 2;
        break;
      end else if (op == 7'b0000011 && f3 == 3'b011) begin
        e.c = sx12(w[31:20]); e.act = t + 5;
        if (e.rw != 0) exp_q.push_back(e);
        t += 5;
      end else if (op == 7'b0100011 && f3 == 3'b011) begin
        e.mem = 1; e.c = sx12({w[31:25], w[11:7]}); e.act = t + 4;
        exp_q.push_back(e);
        t += 4;
      end else if (op == 7'b0110011 && f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
        e.sinal = (f7 == 7'b0100000); e.smux = 1; e.act = t + 4;
        if (e.rw != 0) exp_q.push_back(e);
        t += 4;
      end else if (op == 7'b0010011 && f3 == 3'b000) begin
        e.c = sx12(w[31:20]); e.smux = 1; e.act = t + 4;
        if (e.rw != 0) exp_q.push_back(e);
        t += 4;
      end else begin
        exp_halt = 1; exp_ill = 1; halt_at = t + 2;
        break;
      end
      pc = (pc + 4) % 256;
    end
    t_end  = t;
    end_pc = pc;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    rd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
    rs1 = 5'($urandom); rs2 = 5'($urandom); imm = 12'($urandom);
    case ($urandom_range(0, 4))
      0:       return {imm, rs1, 3'b011, rd, 7'b0000011};
      1:       return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      2:       return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3:       return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      default: return {imm, rs1, 3'b000, rd, 7'b0010011};
    endcase
  endfunction

  function automatic logic [31:0] rand_illegal();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_007F;
      1:       return {12'h004, 5'd1, 3'b010, 5'd2, 7'b0000011};
      2:       return {7'b0000001, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0110011};
      default: return {12'h001, 5'd0, 3'b001, 5'd1, 7'b0010011};
    endcase
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic start_prog(input int max_instr);
    @(posedge clk);
    #1 rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    build_model(max_instr);
    chk("rst_instr_addr", instr_addr, 0);
    chk("rst_C", C, 0);
    chk("rst_ctrl", {Ra, Rb, Rw, sinal, sinalMux, weReg, weMem, halt, illegal}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; run = 1'b1;
  endtask

  task automatic run_prog(input int pct);
    int cyc  = 0;
    int tail = 0;
    bit done = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      if (exp_halt ? (halt_seen && tail >= 4) : (act_cnt >= t_end)) begin
        done = 1;
      end else begin
        if (halt_seen) tail++;
        #1 run = ($urandom_range(0, 99) < pct);
      end
    end
    #1 run = 1'b0;
    chk("prog_timeout", done, 1);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("halt_flag", halt, exp_halt);
    chk("illegal_flag", illegal, exp_ill);
    if (exp_halt) chk("halt_cycle", halt_act, halt_at);
    else chk("end_pc", instr_addr, end_pc);
  endtask

  initial begin
    // Directed program: ld, add, sub, sd, addi, add x0, ecall.
    clear_rom();
    rom[0] = 32'h0080_3083; rom[1] = 32'h0011_01B3; rom[2] = 32'h4011_8233;
    rom[3] = 32'h0040_3823; rom[4] = 32'hFFF0_0293; rom[5] = 32'h0010_8033;
    rom[6] = 32'h0000_0073;
    start_prog(64);
    run_prog(100);

    // Stall in WB for three cycles, then check held fields in the following FETCH.
    clear_rom();
    rom[0] = 32'h0011_01B3; rom[1] = 32'h0000_0073;
    start_prog(64);
    @(negedge clk);
    @(negedge clk);
    chk("dec_instr_addr", instr_addr, 4);
    chk("dec_Ra", Ra, 2);
    chk("dec_Rb", Rb, 1);
    chk("dec_Rw", Rw, 3);
    chk("dec_sinalMux", sinalMux, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_weReg", weReg, 0);
      chk("stall_Rw", Rw, 3);
      @(posedge clk); #1;
      if (i == 2) run = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    chk("fetch_hold_Ra", Ra, 2);
    chk("fetch_hold_sinalMux", sinalMux, 1);
    run_prog(100);

    // Reset arriving during MEM of sd.
    clear_rom();
    rom[0] = 32'h0040_3823; rom[1] = 32'h0000_0073;
    start_prog(64);
    for (int i = 0; i < 20 && !weMem; i++) @(negedge clk);
    chk("sd_mem_reached", weMem, 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_weMem", weMem, 0);
    chk("midrst_instr_addr", instr_addr, 0);
    chk("midrst_queue", exp_q.size(), 0);
    build_model(64);
    @(posedge clk);
    #1 rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    chk("midrst_fetch_addr", instr_addr, 0);
    @(negedge clk);
    chk("midrst_decode_addr", instr_addr, 4);
    run_prog(100);

    // Illegal opcode stops the program.
    clear_rom();
    rom[0] = {12'd5, 5'd0, 3'b000, 5'd7, 7'b0010011}; rom[1] = 32'h0000_007F;
    start_prog(64);
    run_prog(70);

    // Full ROM of non-halting instructions: PC wraps past 0xFC.
    for (int i = 0; i < 64; i++) rom[i] = rand_legal();
    start_prog(70);
    run_prog(80);

    // Random programs ending in ecall or an unsupported encoding.
    for (int p = 0; p < 6; p++) begin
      int len;
      clear_rom();
      len = $urandom_range(4, 20);
      for (int i = 0; i < len; i++) rom[i] = rand_legal();
      rom[len] = (p % 2 == 0) ? 32'h0000_0073 : rand_illegal();
      start_prog(64);
      run_prog($urandom_range(50, 100));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
